// File: rtl/vec_test_engine.sv
// rtl/vec_test_engine.sv - self-test sequencer applying a loadable vector table to a combinational DUT
module vec_test_engine #(
    parameter int N_IN   = 4,
    parameter int N_VEC  = 16,
    parameter int SETTLE = 1,
    parameter int AW     = (N_VEC > 1) ? $clog2(N_VEC) : 1,
    parameter int CW     = $clog2(N_VEC + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            vec_we,
    input  logic [AW-1:0]   vec_waddr,
    input  logic [N_IN:0]   vec_wdata,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CW-1:0]   err_count,
    output logic            mismatch,
    output logic            fail_valid,
    output logic [AW-1:0]   fail_idx,
    output logic [AW-1:0]   vec_idx
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    logic [N_IN:0] tbl [2**AW];
    logic [SW-1:0] settle_cnt;
    logic          exp_y;
    logic          addr_ok;

    // Addresses past the last vector only exist when N_VEC is not a power of two.
    generate
        if ((2**AW) == N_VEC) begin : g_full
            assign addr_ok = 1'b1;
        end else begin : g_part
            assign addr_ok = ({1'b0, vec_waddr} < (AW+1)'(N_VEC));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (vec_we && !busy && addr_ok) begin
            tbl[vec_waddr] <= vec_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            mismatch   <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            vec_idx    <= '0;
            settle_cnt <= '0;
            exp_y      <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_idx   <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        vec_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= S_APPLY;
                    end else if (state == S_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                S_APPLY: begin
                    dut_in     <= tbl[vec_idx][N_IN:1];
                    exp_y      <= tbl[vec_idx][0];
                    settle_cnt <= SW'(SETTLE);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    settle_cnt <= settle_cnt - SW'(1);
                    if (settle_cnt == SW'(1)) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dut_y != exp_y) begin
                        mismatch  <= 1'b1;
                        err_count <= err_count + CW'(1);
                        if (!fail_valid) begin
                            fail_idx   <= vec_idx;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec_idx == AW'(N_VEC - 1)) begin
                        state <= S_DONE;
                    end else begin
                        vec_idx <= vec_idx + AW'(1);
                        state   <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_test_engine.sv
// tb/tb_vec_test_engine.sv - directed bench for vec_test_engine with combinational and delayed parity DUTs
module tb_vec_test_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       we;
    logic [1:0] sel;
    logic [3:0] waddr;
    logic [4:0] wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kstart = 0;
    int mis_total = 0;
    int mis_base = 0;
    int len;

    logic start_a, start_b, start_c, we_a, we_b, we_c;
    logic [3:0] din_a, din_b, din_c, fidx_a, fidx_b, fidx_c, vidx_a, vidx_b, vidx_c;
    logic [4:0] err_a, err_b, err_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic mis_a, mis_b, mis_c, fv_a, fv_b, fv_c;
    logic y_a, d1_b, d2_b, d1_c, d2_c;

    logic [3:0] din_s, fidx_s, vidx_s;
    logic [4:0] err_s;
    logic busy_s, done_s, pass_s, mis_s, fv_s;

    // sel: 0 = A (comb, SETTLE=1), 1 = B (2-cycle DUT, SETTLE=1), 2 = C (2-cycle DUT, SETTLE=3), 3 = load all tables
    assign start_a = start && (sel == 2'd0);
    assign start_b = start && (sel == 2'd1);
    assign start_c = start && (sel == 2'd2);
    assign we_a    = we && (sel == 2'd0 || sel == 2'd3);
    assign we_b    = we && (sel == 2'd1 || sel == 2'd3);
    assign we_c    = we && (sel == 2'd2 || sel == 2'd3);

    assign y_a = ^din_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_b <= 1'b0; d2_b <= 1'b0; d1_c <= 1'b0; d2_c <= 1'b0;
        end else begin
            d1_b <= ^din_b; d2_b <= d1_b;
            d1_c <= ^din_c; d2_c <= d1_c;
        end
    end

    vec_test_engine #(.N_IN(4), .N_VEC(16), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vec_we(we_a), .vec_waddr(waddr),
        .vec_wdata(wdata), .dut_in(din_a), .dut_y(y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .mismatch(mis_a), .fail_valid(fv_a),
        .fail_idx(fidx_a), .vec_idx(vidx_a));

    vec_test_engine #(.N_IN(4), .N_VEC(16), .SETTLE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vec_we(we_b), .vec_waddr(waddr),
        .vec_wdata(wdata), .dut_in(din_b), .dut_y(d2_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .mismatch(mis_b), .fail_valid(fv_b),
        .fail_idx(fidx_b), .vec_idx(vidx_b));

    vec_test_engine #(.N_IN(4), .N_VEC(16), .SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .vec_we(we_c), .vec_waddr(waddr),
        .vec_wdata(wdata), .dut_in(din_c), .dut_y(d2_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .mismatch(mis_c), .fail_valid(fv_c),
        .fail_idx(fidx_c), .vec_idx(vidx_c));

    always_comb begin
        case (sel)
            2'd1: begin
                din_s = din_b; fidx_s = fidx_b; vidx_s = vidx_b; err_s = err_b;
                busy_s = busy_b; done_s = done_b; pass_s = pass_b; mis_s = mis_b; fv_s = fv_b;
            end
            2'd2: begin
                din_s = din_c; fidx_s = fidx_c; vidx_s = vidx_c; err_s = err_c;
                busy_s = busy_c; done_s = done_c; pass_s = pass_c; mis_s = mis_c; fv_s = fv_c;
            end
            default: begin
                din_s = din_a; fidx_s = fidx_a; vidx_s = vidx_a; err_s = err_a;
                busy_s = busy_a; done_s = done_a; pass_s = pass_a; mis_s = mis_a; fv_s = fv_a;
            end
        endcase
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mis_s === 1'b1) mis_total <= mis_total + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
        check({tag, "_mismatch"}, 32'(mis_a), 32'd0);
        check({tag, "_fail_valid"}, 32'(fv_a), 32'd0);
        check({tag, "_err_count"}, 32'(err_a), 32'd0);
        check({tag, "_dut_in"}, 32'(din_a), 32'd0);
        check({tag, "_vec_idx"}, 32'(vidx_a), 32'd0);
    endtask

    task automatic start_run(input string tag);
        mis_base = mis_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        kstart = cyc;
        check({tag, "_busy_rise"}, 32'(busy_s), 32'd1);
        check({tag, "_done_fall"}, 32'(done_s), 32'd0);
    endtask

    task automatic wait_done(input string tag, output int run_len);
        int n = 0;
        while (done_s !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_reached"}, 32'(done_s), 32'd1);
        check({tag, "_busy_fall"}, 32'(busy_s), 32'd0);
        run_len = cyc - kstart;
    endtask

    task automatic write_vec(input int idx, input logic flip);
        logic [3:0] v;
        v = idx[3:0];
        we = 1'b1;
        waddr = v;
        wdata = {v, (^v) ^ flip};
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 2'd0;
        start = 1'($urandom);
        we    = 1'($urandom);
        waddr = 4'($urandom);
        wdata = 5'($urandom);
        tick();
        start = 1'($urandom);
        waddr = 4'($urandom);
        tick();
        check_reset_outputs("in_reset");
        start = 1'b0;
        we    = 1'b0;
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset");

        sel = 2'd3;
        for (int i = 0; i < 16; i++) write_vec(i, 1'b0);

        // Clean run: vector i is applied on edge k+1+3i
        sel = 2'd0;
        start_run("clean");
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("clean_dut_in_%0d", i), 32'(din_a), 32'(i));
            tick();
            tick();
        end
        wait_done("clean", len);
        check("clean_len", 32'(len), 32'd49);
        check("clean_pass", 32'(pass_a), 32'd1);
        check("clean_err", 32'(err_a), 32'd0);
        check("clean_fail_valid", 32'(fv_a), 32'd0);
        check("clean_mismatch_cnt", 32'(mis_total - mis_base), 32'd0);
        check("clean_dut_in_hold", 32'(din_a), 32'hf);

        write_vec(3, 1'b1);
        write_vec(10, 1'b1);
        start_run("corrupt");
        wait_done("corrupt", len);
        check("corrupt_len", 32'(len), 32'd49);
        check("corrupt_mismatch_cnt", 32'(mis_total - mis_base), 32'd2);
        check("corrupt_err", 32'(err_a), 32'd2);
        check("corrupt_fail_valid", 32'(fv_a), 32'd1);
        check("corrupt_fail_idx", 32'(fidx_a), 32'd3);
        check("corrupt_pass", 32'(pass_a), 32'd0);
        write_vec(3, 1'b0);
        write_vec(10, 1'b0);

        // Mid-run start and table write must both be dropped
        start_run("abuse");
        repeat (4) tick();
        start = 1'b1;
        we    = 1'b1;
        waddr = 4'd5;
        wdata = {4'd5, 1'b1};
        tick();
        start = 1'b0;
        we    = 1'b0;
        wait_done("abuse", len);
        check("abuse_len", 32'(len), 32'd49);
        check("abuse_pass", 32'(pass_a), 32'd1);
        start_run("abuse_rerun");
        wait_done("abuse_rerun", len);
        check("abuse_rerun_pass", 32'(pass_a), 32'd1);
        check("abuse_rerun_err", 32'(err_a), 32'd0);

        start_run("midreset");
        while (cyc < kstart + 20) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_async");
        tick();
        tick();
        check_reset_outputs("midreset_held");
        rst_n = 1'b1;
        tick();
        start_run("post_reset");
        wait_done("post_reset", len);
        check("post_reset_len", 32'(len), 32'd49);
        check("post_reset_pass", 32'(pass_a), 32'd1);

        // Two-cycle DUT with SETTLE=1 always sees the previous vector's parity
        sel = 2'd1;
        start_run("settle1");
        wait_done("settle1", len);
        check("settle1_len", 32'(len), 32'd49);
        check("settle1_pass", 32'(pass_b), 32'd0);
        check("settle1_fail_idx", 32'(fidx_b), 32'd1);
        check("settle1_err", 32'(err_b), 32'd10);
        check("settle1_mismatch_cnt", 32'(mis_total - mis_base), 32'd10);

        sel = 2'd2;
        start_run("settle3");
        wait_done("settle3", len);
        check("settle3_len", 32'(len), 32'd81);
        check("settle3_pass", 32'(pass_c), 32'd1);
        check("settle3_err", 32'(err_c), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
